// File: rtl/mult18x18s_arbiter.sv
// rtl/mult18x18s_arbiter.sv - round-robin sharing of one registered 18x18 signed multiplier
//
// Purpose: arbitrates NREQ operand requesters onto a single MULT18X18S-style
// multiplier (1-cycle registered product, CE, synchronous R) and returns each
// product tagged with its requester ID over a backpressured response port.
//
// Ports:
//   C, R                  clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake, req_ready is one-hot
//   req_a, req_b          packed signed 18-bit operands, requester i at [18*i+17:18*i]
//   m_a, m_b, m_ce, m_r   drive the multiplier pins
//   m_p                   registered product from the multiplier
//   rsp_valid/rsp_ready   response handshake
//   rsp_id, rsp_p         requester index and 36-bit signed product
//   ops_count             completed responses, saturating at 0xFFFF

module mult18x18s_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              C,
    input  logic              R,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*18-1:0] req_a,
    input  logic [NREQ*18-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [17:0]       m_a,
    output logic [17:0]       m_b,
    output logic              m_ce,
    output logic              m_r,
    input  logic [35:0]       m_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [35:0]       rsp_p,
    output logic [15:0]       ops_count
);

    logic           pipe_valid_q, pipe_valid_d;
    logic [IDW-1:0] pipe_id_q, pipe_id_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [15:0]    ops_count_q, ops_count_d;

    logic           advance;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;

    // The multiplier's product register is the only pipeline stage; a new
    // operand pair may enter whenever that stage is empty or being drained.
    assign advance = !pipe_valid_q || rsp_ready;

    // Round-robin search starting one past the last winner, wrapping at NREQ.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDW'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Multiplier pin drive; operands are steered even when stalled because
    // CE low keeps the product register from capturing them.
    always_comb begin
        req_ready = '0;
        m_a       = '0;
        m_b       = '0;
        if (grant_found) begin
            m_a = req_a[18*grant_idx +: 18];
            m_b = req_b[18*grant_idx +: 18];
        end
        if (advance && grant_found && !R) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign m_ce = advance && (|req_valid) && !R;
    assign m_r  = R;

    always_comb begin
        pipe_valid_d = pipe_valid_q;
        pipe_id_d    = pipe_id_q;
        last_grant_d = last_grant_q;
        ops_count_d  = ops_count_q;
        if (advance) begin
            pipe_valid_d = grant_found;
            if (grant_found) begin
                pipe_id_d    = grant_idx;
                last_grant_d = grant_idx;
            end
        end
        if (pipe_valid_q && rsp_ready && (ops_count_q != 16'hFFFF)) begin
            ops_count_d = ops_count_q + 16'd1;
        end
    end

    // last_grant resets to NREQ-1 so requester 0 is searched first.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            pipe_valid_q <= 1'b0;
            pipe_id_q    <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            ops_count_q  <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_id_q    <= pipe_id_d;
            last_grant_q <= last_grant_d;
            ops_count_q  <= ops_count_d;
        end
    end

    assign rsp_valid = pipe_valid_q;
    assign rsp_id    = pipe_id_q;
    assign rsp_p     = m_p;
    assign ops_count = ops_count_q;

endmodule

// File: tb/tb_mult18x18s_arbiter.sv
// tb/tb_mult18x18s_arbiter.sv - directed bench for mult18x18s_arbiter

module tb_mult18x18s_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              C;
    logic              R;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*18-1:0] req_a;
    logic [NREQ*18-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [17:0]       m_a;
    logic [17:0]       m_b;
    logic              m_ce;
    logic              m_r;
    logic [35:0]       m_p;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [35:0]       rsp_p;
    logic [15:0]       ops_count;

    int n_chk;
    int n_fail;

    mult18x18s_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .C         (C),
        .R         (R),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_ce      (m_ce),
        .m_r       (m_r),
        .m_p       (m_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .ops_count (ops_count)
    );

    // MULT18X18S-style primitive: registered signed product, CE, sync reset.
    always_ff @(posedge C) begin
        if (m_r) begin
            m_p <= '0;
        end else if (m_ce) begin
            m_p <= 36'($signed(m_a) * $signed(m_b));
        end
    end

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    typedef struct {
        int          id;
        logic [17:0] a;
        logic [17:0] b;
        logic [35:0] p;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int ops_exp;

        vecs[0] = '{0, 18'h00003, 18'h3FFFE, 36'hFFFFFFFFA};
        vecs[1] = '{0, 18'h20000, 18'h20000, 36'h400000000};
        vecs[2] = '{1, 18'h1FFFF, 18'h20000, 36'hC00020000};
        vecs[3] = '{3, 18'h1FFFF, 18'h1FFFF, 36'h3FFFC0001};
        vecs[4] = '{2, 18'h00005, 18'h00007, 36'h000000023};
        vecs[5] = '{1, 18'h3FFFF, 18'h3FFFF, 36'h000000001};
        vecs[6] = '{3, 18'h00000, 18'h12345, 36'h000000000};
        vecs[7] = '{2, 18'h3FFFF, 18'h00005, 36'hFFFFFFFFB};

        n_chk     = 0;
        n_fail    = 0;
        R         = 1'b1;
        req_valid = 4'b0001;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state, with a request pending that must not be accepted.
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_m_ce", m_ce, 0);
        chk("rst_m_r", m_r, 1);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_ops", ops_count, 0);
        tick();
        tick();
        req_valid = '0;
        R = 1'b0;
        ops_exp = 0;

        // Single-requester vectors: grant, 1-cycle product, then drain.
        for (int i = 0; i < 8; i++) begin
            req_a = '0;
            req_b = '0;
            req_a[18*vecs[i].id +: 18] = vecs[i].a;
            req_b[18*vecs[i].id +: 18] = vecs[i].b;
            req_valid = 4'(1 << vecs[i].id);
            #1;
            chk($sformatf("v%0d_req_ready", i), req_ready, 64'(1 << vecs[i].id));
            chk($sformatf("v%0d_m_ce", i), m_ce, 1);
            tick();
            req_valid = '0;
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("v%0d_rsp_id", i), rsp_id, 64'(vecs[i].id));
            chk($sformatf("v%0d_rsp_p", i), rsp_p, vecs[i].p);
            tick();
            ops_exp++;
            chk($sformatf("v%0d_ops", i), ops_count, 64'(ops_exp));
            chk($sformatf("v%0d_rsp_idle", i), rsp_valid, 0);
        end

        // Round-robin streaming, all four requesters, operand a=i+1, b=10.
        R = 1'b1;
        tick();
        R = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[18*i +: 18] = 18'(i + 1);
            req_b[18*i +: 18] = 18'd10;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("rr%0d_req_ready", c), req_ready, 64'(1 << (c % 4)));
            tick();
            chk($sformatf("rr%0d_rsp_valid", c), rsp_valid, 1);
            chk($sformatf("rr%0d_rsp_id", c), rsp_id, 64'(c % 4));
            chk($sformatf("rr%0d_rsp_p", c), rsp_p, 64'(((c % 4) + 1) * 10));
        end

        // Backpressure for 3 cycles: everything holds on requester 3's product.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_m_ce", c), m_ce, 0);
            chk($sformatf("bp%0d_req_ready", c), req_ready, 0);
            chk($sformatf("bp%0d_rsp_valid", c), rsp_valid, 1);
            chk($sformatf("bp%0d_rsp_id", c), rsp_id, 3);
            chk($sformatf("bp%0d_rsp_p", c), rsp_p, 40);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_req_ready", req_ready, 4'b0001);
        tick();
        chk("bp_rel_rsp_id", rsp_id, 0);
        chk("bp_rel_rsp_p", rsp_p, 10);
        chk("bp_rel_ops", ops_count, 8);

        // Asynchronous reset mid-stream discards the in-flight product.
        R = 1'b1;
        #1;
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_ops", ops_count, 0);
        chk("mr_m_r", m_r, 1);
        chk("mr_req_ready", req_ready, 0);
        chk("mr_m_ce", m_ce, 0);
        tick();
        tick();
        req_valid = 4'b0101;
        R = 1'b0;
        #1;
        chk("mr_first_grant", req_ready, 4'b0001);
        tick();
        chk("mr_rsp_id0", rsp_id, 0);
        chk("mr_rsp_p0", rsp_p, 10);
        chk("mr_second_grant", req_ready, 4'b0100);
        tick();
        chk("mr_rsp_id2", rsp_id, 2);
        chk("mr_rsp_p2", rsp_p, 30);

        // Saturation: one accepted response per cycle after the first edge.
        R = 1'b1;
        tick();
        req_valid = 4'b0001;
        R = 1'b0;
        repeat (65535) @(posedge C);
        #1;
        chk("sat_fffe", ops_count, 16'hFFFE);
        tick();
        chk("sat_ffff", ops_count, 16'hFFFF);
        repeat (5) @(posedge C);
        #1;
        chk("sat_hold", ops_count, 16'hFFFF);
        chk("sat_rsp_valid", rsp_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
